flap_input: RTL



---
 rtl/flap_input_pkg.sv | 47 ++++
 rtl/flap_input_debouncer.sv | 123 ++++++++++++
 rtl/flap_input.sv | 99 +++++++++
 3 files changed

// File: rtl/flap_input_pkg.sv
// Shared game-control definitions: debounce FSM encoding, default timing
// constants and the flap arbitration decision used by flap_input.
package flap_input_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } debounce_state_t;

  // Defaults sized for the pixel clock: ~1 ms debounce, ~100 ms between flaps.
  localparam int unsigned SYNC_STAGES_DEFAULT     = 2;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 65000;
  localparam int unsigned HOLDOFF_CYCLES_DEFAULT  = 6500000;

  typedef enum logic [2:0] {
    ACT_IDLE       = 3'd0,
    ACT_FLUSH      = 3'd1,
    ACT_FLUSH_DROP = 3'd2,
    ACT_FLAP       = 3'd3,
    ACT_BUFFER     = 3'd4,
    ACT_DROP       = 3'd5
  } arb_action_t;

  function automatic logic is_held(input debounce_state_t st);
    return (st == PRESSED) || (st == RELEASE_WAIT);
  endfunction

  // Priority: disabled game wins, then an expired holdoff, then buffering.
  function automatic arb_action_t arbitrate(input logic en,
                                            input logic hold_done,
                                            input logic pending,
                                            input logic press_evt);
    arb_action_t act;
    act = ACT_IDLE;
    if (!en) begin
      act = press_evt ? ACT_FLUSH_DROP : ACT_FLUSH;
    end else if (hold_done && (pending || press_evt)) begin
      act = ACT_FLAP;
    end else if (press_evt) begin
      act = pending ? ACT_DROP : ACT_BUFFER;
    end
    return act;
  endfunction

endpackage

// File: rtl/flap_input_debouncer.sv
// Synchronizes the raw button level and debounces it; emits the debounced
// level and a one-cycle event when a press is accepted.
module flap_input_debouncer
  import flap_input_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic left_async,
  output logic held,
  output logic press_evt
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  debounce_state_t        state;
  debounce_state_t        state_next;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_next;
  logic [CW-1:0]          cnt_inc;
  logic                   evt_next;
  logic                   held_next;

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], left_async};
    end
  end

  assign s       = sync[SYNC_STAGES-1];
  assign cnt_inc = cnt + CNT_ONE;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= RELEASED;
      cnt       <= '0;
      press_evt <= 1'b0;
      held      <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      press_evt <= evt_next;
      held      <= held_next;
    end
  end

  // The sample that starts a wait counts as the first stable sample, so a
  // single-cycle debounce switches state on the first differing sample.
  // NOTE: every output of this block gets a default first so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    evt_next   = 1'b0;
    unique case (state)
      RELEASED: begin
        if (s) begin
          if (CNT_ONE == CNT_LAST) begin
            state_next = PRESSED;
            evt_next   = 1'b1;
            cnt_next   = '0;
          end else begin
            state_next = PRESS_WAIT;
            cnt_next   = CNT_ONE;
          end
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_next = RELEASED;
          cnt_next   = '0;
        end else if (cnt_inc == CNT_LAST) begin
          state_next = PRESSED;
          evt_next   = 1'b1;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      PRESSED: begin
        if (!s) begin
          if (CNT_ONE == CNT_LAST) begin
            state_next = RELEASED;
            cnt_next   = '0;
          end else begin
            state_next = RELEASE_WAIT;
            cnt_next   = CNT_ONE;
          end
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else if (cnt_inc == CNT_LAST) begin
          state_next = RELEASED;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      default: begin
        state_next = RELEASED;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    held_next = is_held(state);
  end

endmodule

// File: rtl/flap_input.sv
// Turns the raw mouse left-button level into rate-limited flap requests,
// buffering at most one press that arrives during the holdoff window.
module flap_input
  import flap_input_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned HOLDOFF_CYCLES  = HOLDOFF_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic left_async,
  input  logic enable,
  output logic flap,
  output logic held,
  output logic dropped
);

  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF_CYCLES);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

  logic          press_evt;
  logic [HW-1:0] hcnt;
  logic [HW-1:0] hcnt_next;
  logic          pending;
  logic          pending_next;
  logic          flap_next;
  logic          dropped_next;
  arb_action_t   action;

  flap_input_debouncer #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk       (clk),
    .rst       (rst),
    .left_async(left_async),
    .held      (held),
    .press_evt (press_evt)
  );

  assign action = arbitrate(enable, (hcnt == '0), pending, press_evt);

  always_comb begin
    pending_next = pending;
    flap_next    = 1'b0;
    dropped_next = 1'b0;
    unique case (action)
      ACT_FLUSH: begin
        pending_next = 1'b0;
      end
      ACT_FLUSH_DROP: begin
        pending_next = 1'b0;
        dropped_next = 1'b1;
      end
      ACT_FLAP: begin
        flap_next    = 1'b1;
        pending_next = 1'b0;
      end
      ACT_BUFFER: begin
        pending_next = 1'b1;
      end
      ACT_DROP: begin
        dropped_next = 1'b1;
      end
      default: begin
        pending_next = pending;
      end
    endcase
  end

  // Holdoff keeps running while the game is disabled so a re-enable after a
  // long pause accepts the next press immediately.
  always_comb begin
    if (flap_next) begin
      hcnt_next = HOLD_LOAD;
    end else if (hcnt != '0) begin
      hcnt_next = hcnt - HOLD_ONE;
    end else begin
      hcnt_next = hcnt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hcnt    <= '0;
      pending <= 1'b0;
      flap    <= 1'b0;
      dropped <= 1'b0;
    end else begin
      hcnt    <= hcnt_next;
      pending <= pending_next;
      flap    <= flap_next;
      dropped <= dropped_next;
    end
  end

endmodule
